// File: rtl/note_sequencer_if.sv
// Control/status bundle for note_sequencer: start/snapshot inputs toward the
// sequencer, tone and progress outputs back to whoever drives it.
interface note_sequencer_if #(
  parameter int NUM_NOTES = 3,
  parameter int FREQ_W    = 10,
  parameter int DUR_W     = 8,
  parameter int REP_W     = 2
);
  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  logic                                   start;
  logic [NUM_NOTES*(FREQ_W+DUR_W)-1:0]    notes;
  logic [REP_W-1:0]                       repeats;
  logic                                   pwm;
  logic                                   busy;
  logic [IDX_W-1:0]                       note_idx;
  logic                                   done;

  modport master (output start, notes, repeats, input pwm, busy, note_idx, done);
  modport slave  (input start, notes, repeats, output pwm, busy, note_idx, done);
endinterface

// File: rtl/note_sequencer.sv
// Plays NUM_NOTES (freq, dur) pairs repeats+1 times using an NCO tone and a tick prescaler.
// Define NOTE_SEQ_GAP_EN to insert a silent GAP of GAP_TICKS ticks after every note.
module note_sequencer #(
  parameter int NUM_NOTES = 3,
  parameter int FREQ_W    = 10,
  parameter int DUR_W     = 8,
  parameter int REP_W     = 2,
  parameter int CLK_HZ    = 24_000_000,
  parameter int TICK_HZ   = 100,
  parameter int ACC_W     = 32,
  parameter int GAP_TICKS = 1
) (
  input logic             int_osc,
  input logic             reset,
  note_sequencer_if.slave bus
);
  localparam int NOTE_W   = FREQ_W + DUR_W;
  localparam int IDX_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int GAP_CW   = $clog2(GAP_TICKS + 1);
  localparam int CNT_W    = (DUR_W > GAP_CW) ? DUR_W : GAP_CW;

  localparam longint unsigned INC_SCALE = (64'd1 << ACC_W) / CLK_HZ;
  localparam logic [ACC_W-1:0] INC_K    = ACC_W'(INC_SCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
`ifdef NOTE_SEQ_GAP_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif

  logic [1:0]                  state;
  logic                        busy_r;
  logic                        done_r;
  logic [IDX_W-1:0]            idx;
  logic [REP_W-1:0]            pass;
  logic [PRE_W-1:0]            presc;
  logic [CNT_W-1:0]            cnt;
  logic [ACC_W-1:0]            acc;
  logic [NUM_NOTES*NOTE_W-1:0] notes_sh;
  logic [REP_W-1:0]            repeats_sh;

  logic [FREQ_W-1:0] cur_freq;
  logic [DUR_W-1:0]  cur_dur;
  logic [ACC_W-1:0]  inc;
  logic              tick_wrap;
  logic              note_end;
  logic [1:0]        adv_state;
  logic [IDX_W-1:0]  adv_idx;
  logic [REP_W-1:0]  adv_pass;
  logic              adv_done;

  // Mux loop keeps the note select in range for non-power-of-two NUM_NOTES.
  always_comb begin
    cur_freq = '0;
    cur_dur  = '0;
    for (int k = 0; k < NUM_NOTES; k++) begin
      if (idx == IDX_W'(k)) begin
        {cur_freq, cur_dur} = notes_sh[k*NOTE_W +: NOTE_W];
      end
    end
  end

  assign inc       = ACC_W'(cur_freq) * INC_K;
  assign tick_wrap = (presc == PRE_LAST);
  assign note_end  = (cur_dur == '0) || (tick_wrap && (cnt + CNT_W'(1) == CNT_W'(cur_dur)));

  // What follows the current note: next note, next pass, or finish.
  always_comb begin
    adv_state = PLAY;
    adv_idx   = idx;
    adv_pass  = pass;
    adv_done  = 1'b0;
    if (idx != IDX_LAST) begin
      adv_idx = idx + 1'b1;
    end else if (pass < repeats_sh) begin
      adv_idx  = '0;
      adv_pass = pass + 1'b1;
    end else begin
      adv_state = IDLE;
      adv_done  = 1'b1;
    end
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      idx        <= '0;
      pass       <= '0;
      presc      <= '0;
      cnt        <= '0;
      acc        <= '0;
      notes_sh   <= '0;
      repeats_sh <= '0;
    end else if (bus.start) begin
      notes_sh   <= bus.notes;
      repeats_sh <= bus.repeats;
      state      <= PLAY;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      idx        <= '0;
      pass       <= '0;
      presc      <= '0;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        PLAY: begin
          if (note_end) begin
            // Clearing acc here makes every note (and GAP/IDLE) start with pwm low.
            acc   <= '0;
            presc <= '0;
            cnt   <= '0;
`ifdef NOTE_SEQ_GAP_EN
            state <= GAP;
`else
            state  <= adv_state;
            idx    <= adv_idx;
            pass   <= adv_pass;
            busy_r <= ~adv_done;
            done_r <= adv_done;
`endif
          end else begin
            acc   <= acc + inc;
            presc <= tick_wrap ? '0 : presc + 1'b1;
            if (tick_wrap) cnt <= cnt + 1'b1;
          end
        end
`ifdef NOTE_SEQ_GAP_EN
        GAP: begin
          if (tick_wrap && (cnt + CNT_W'(1) == CNT_W'(GAP_TICKS))) begin
            presc  <= '0;
            cnt    <= '0;
            state  <= adv_state;
            idx    <= adv_idx;
            pass   <= adv_pass;
            busy_r <= ~adv_done;
            done_r <= adv_done;
          end else begin
            presc <= tick_wrap ? '0 : presc + 1'b1;
            if (tick_wrap) cnt <= cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.pwm      = acc[ACC_W-1];
  assign bus.busy     = busy_r;
  assign bus.note_idx = idx;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a per-cycle expectation stream is built from the
// note list at each start, and a negedge monitor pops and compares it against the DUT.
module tb_note_sequencer;
  localparam int NUM_NOTES = 3;
  localparam int FREQ_W    = 10;
  localparam int DUR_W     = 8;
  localparam int REP_W     = 2;
  localparam int NOTE_W    = FREQ_W + DUR_W;
  localparam int TICK_CYC  = 8;
  localparam int INC_SCALE = 64;
`ifdef NOTE_SEQ_GAP_EN
  localparam int GAP_CYC   = TICK_CYC;
`else
  localparam int GAP_CYC   = 0;
`endif

  typedef struct {
    bit pwm;
    bit busy;
    int idx;
    bit done;
    bit chk_idx;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   mon_en;
  exp_t exp_q[$];
  exp_t mon_e;

  note_sequencer_if #(.NUM_NOTES(NUM_NOTES), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .REP_W(REP_W)) bus ();

  note_sequencer #(
    .NUM_NOTES(NUM_NOTES), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .REP_W(REP_W),
    .CLK_HZ(1024), .TICK_HZ(128), .ACC_W(16), .GAP_TICKS(1)
  ) dut (
    .int_osc(clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NUM_NOTES*NOTE_W-1:0] packNotes(input int f0, input int d0,
                                                            input int f1, input int d1,
                                                            input int f2, input int d2);
    logic [NUM_NOTES*NOTE_W-1:0] v;
    v = {FREQ_W'(f2), DUR_W'(d2), FREQ_W'(f1), DUR_W'(d1), FREQ_W'(f0), DUR_W'(d0)};
    return v;
  endfunction

  // Reference: each note is dur*TICK_CYC cycles (1 if dur=0); pwm is the MSB of c*freq*64 mod 2^16.
  task automatic buildExpect(input logic [NUM_NOTES*NOTE_W-1:0] nv, input int rep);
    exp_t e;
    for (int p = 0; p <= rep; p++) begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        logic [NOTE_W-1:0] n;
        int f, d, a;
        n = nv[k*NOTE_W +: NOTE_W];
        f = int'(n[NOTE_W-1 -: FREQ_W]);
        d = int'(n[DUR_W-1:0]);
        if (d == 0) begin
          e = '{pwm: 1'b0, busy: 1'b1, idx: k, done: 1'b0, chk_idx: 1'b1};
          exp_q.push_back(e);
        end else begin
          for (int c = 0; c < d * TICK_CYC; c++) begin
            a = (c * f * INC_SCALE) % 65536;
            e = '{pwm: (a >= 32768), busy: 1'b1, idx: k, done: 1'b0, chk_idx: 1'b1};
            exp_q.push_back(e);
          end
        end
        for (int g = 0; g < GAP_CYC; g++) begin
          e = '{pwm: 1'b0, busy: 1'b1, idx: k, done: 1'b0, chk_idx: 1'b1};
          exp_q.push_back(e);
        end
      end
    end
    e = '{pwm: 1'b0, busy: 1'b0, idx: 0, done: 1'b1, chk_idx: 1'b0};
    exp_q.push_back(e);
  endtask

  // Pulses start with the given snapshot, then scrambles the inputs to prove they are ignored.
  task automatic applyStimulus(input logic [NUM_NOTES*NOTE_W-1:0] nv, input int rep);
    bus.notes   = nv;
    bus.repeats = REP_W'(rep);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_q.delete();
    buildExpect(nv, rep);
    bus.notes   = packNotes($urandom_range(511), $urandom_range(3), $urandom_range(511),
                            $urandom_range(3), $urandom_range(511), $urandom_range(3));
    bus.repeats = REP_W'($urandom_range(3));
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("pwm", int'(bus.pwm), int'(mon_e.pwm));
          checkOutput("busy", int'(bus.busy), int'(mon_e.busy));
          checkOutput("done", int'(bus.done), int'(mon_e.done));
          if (mon_e.chk_idx) checkOutput("note_idx", int'(bus.note_idx), mon_e.idx);
        end else begin
          checkOutput("idle_pwm", int'(bus.pwm), 0);
          checkOutput("idle_busy", int'(bus.busy), 0);
          checkOutput("idle_done", int'(bus.done), 0);
        end
      end
    end
  end

  initial begin
    logic [NUM_NOTES*NOTE_W-1:0] tune;
    checks      = 0;
    errors      = 0;
    mon_en      = 1'b0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.notes   = '0;
    bus.repeats = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_note_idx", int'(bus.note_idx), 0);
    @(posedge clk);
    #1;

    $display("[TB] basic tune");
    tune = packNotes(128, 2, 256, 1, 0, 3);
    applyStimulus(tune, 0);
    waitIdle(200);

    $display("[TB] tune with repeats=2");
    applyStimulus(tune, 2);
    waitIdle(400);

    $display("[TB] zero-duration middle note");
    applyStimulus(packNotes(128, 2, 256, 0, 0, 3), 0);
    waitIdle(200);

    $display("[TB] restart mid-playback");
    applyStimulus(tune, 1);
    repeat (18) @(posedge clk);
    #1;
    applyStimulus(packNotes(64, 1, 256, 1, 128, 1), 0);
    waitIdle(200);

    $display("[TB] reset mid-playback");
    applyStimulus(tune, 3);
    repeat (9) @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    bus.notes = packNotes(300, 2, 100, 1, 50, 1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("abort_note_idx", int'(bus.note_idx), 0);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] randomized runs");
    for (int r = 0; r < 16; r++) begin
      applyStimulus(packNotes($urandom_range(511), $urandom_range(3), $urandom_range(511),
                              $urandom_range(3), $urandom_range(511), $urandom_range(3)),
                    $urandom_range(3));
      waitIdle(1500);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
